// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: replays a solved Knight's tour as paired vertical/horizontal
// move commands for cmd_proc, and passes UART commands straight through when
// no tour is being replayed. Owns the index into the solver's move memory.
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [4:0]  mv_indx,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    localparam logic [4:0] LAST_IDX  = 5'(NUM_MOVES - 1);
    localparam logic [3:0] OP_MOVE   = 4'h4;
    localparam logic [3:0] OP_FANFR  = 4'h5;
    localparam logic [7:0] HEAD_N    = 8'h00;
    localparam logic [7:0] HEAD_S    = 8'h7F;
    localparam logic [7:0] HEAD_E    = 8'hBF;
    localparam logic [7:0] HEAD_W    = 8'h3F;
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    state_t      state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;

    logic [2:0]  move_bit;
    logic        dx_pos, dy_pos;
    logic [3:0]  dx_mag, dy_mag;
    logic [15:0] vert_cmd, horz_cmd;
    logic        last_move;

    // Decode the (lowest set bit of the) one-hot move into signed leg lengths.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        move_bit = 3'd0;
        dx_pos   = 1'b1;
        dy_pos   = 1'b1;
        dx_mag   = 4'd1;
        dy_mag   = 4'd2;
        // Scanning downward leaves the lowest set bit; all-zero stays bit 0.
        for (int i = 7; i >= 0; i--) begin
            if (move[i]) move_bit = 3'(i);
        end
        case (move_bit)
            3'd0: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
            3'd1: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
            3'd2: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
            3'd3: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
            3'd4: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
            3'd5: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
            3'd6: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
            3'd7: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
            default: ;
        endcase
    end

    assign vert_cmd  = {OP_MOVE,  (dy_pos ? HEAD_N : HEAD_S), dy_mag};
    assign horz_cmd  = {OP_FANFR, (dx_pos ? HEAD_E : HEAD_W), dx_mag};
    assign last_move = (mv_indx_q == LAST_IDX);

    // Next-state and move-index logic, paced by the cmd_proc handshake.
    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        case (state_q)
            IDLE: begin
                if (start_tour) begin
                    mv_indx_d = 5'd0;
                    state_d   = VERT;
                end
            end
            VERT:   if (clr_cmd_rdy) state_d = HOLD_V;
            HOLD_V: if (send_resp)   state_d = HORZ;
            HORZ:   if (clr_cmd_rdy) state_d = HOLD_H;
            HOLD_H: begin
                if (send_resp) begin
                    if (last_move) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + 5'd1;
                        state_d   = VERT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and move-index registers; reset abandons any tour in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mv_indx_q <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    // Command mux and response byte decoded from the current state.
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = 1'b0;
        resp    = RESP_BUSY;
        case (state_q)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
            end
            HOLD_V: cmd = vert_cmd;
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            HOLD_H: begin
                cmd  = horz_cmd;
                resp = last_move ? RESP_DONE : RESP_BUSY;
            end
            default: ;
        endcase
    end

    assign mv_indx = mv_indx_q;

endmodule
